// File: rtl/nn_resistance_ctrl.sv
// nn_resistance_ctrl
// Dynamic resistance controller for a polar smooth-gradient parameter unit.
// Each accepted direction reversal raises RESISTANCE by one, and a long quiet
// period lowers it by one. A holdoff window after every accepted reversal
// keeps a burst of reversals from counting more than once.

module nn_resistance_ctrl #(
    parameter int N_RESISTANCE = 9,
    parameter int R_MIN        = 1,
    parameter int R_MAX        = 100,
    parameter int HOLDOFF      = 16,
    parameter int DECAY_PERIOD = 256,
    parameter int N_DECAY      = 12
) (
    input  logic                    CLK,
    input  logic                    INIT,
    input  logic                    EN,
    input  logic                    TRANS_TRIG,
    input  logic [N_RESISTANCE-1:0] RESISTANCE_INIT,
    output logic [N_RESISTANCE-1:0] RESISTANCE,
    output logic                    RES_CHANGED,
    output logic                    AT_MAX,
    output logic                    AT_MIN,
    output logic [7:0]              INC_COUNT
);

    // A width of $clog2(HOLDOFF+1) stays at least one bit wide even when HOLDOFF is 1.
    localparam int N_HOLD = $clog2(HOLDOFF + 1);

    localparam logic [N_RESISTANCE-1:0] R_MIN_V   = N_RESISTANCE'(R_MIN);
    localparam logic [N_RESISTANCE-1:0] R_MAX_V   = N_RESISTANCE'(R_MAX);
    localparam logic [N_DECAY-1:0]      DECAY_TC  = N_DECAY'(DECAY_PERIOD - 1);
    localparam logic [N_HOLD-1:0]       HOLD_LOAD = N_HOLD'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HOLDOFF = 2'd1
    } state_t;

    state_t                  state;
    logic [N_RESISTANCE-1:0] res_reg;
    logic [N_RESISTANCE-1:0] init_clamped;
    logic [N_DECAY-1:0]      quiet_cnt;
    logic [N_HOLD-1:0]       hold_cnt;
    logic                    trig_prev;
    logic                    trig_edge;

    // Clamp the load value so the register never holds anything outside [R_MIN,R_MAX].
    always_comb begin
        init_clamped = RESISTANCE_INIT;
        if (RESISTANCE_INIT < R_MIN_V) begin
            init_clamped = R_MIN_V;
        end else if (RESISTANCE_INIT > R_MAX_V) begin
            init_clamped = R_MAX_V;
        end
    end

    // Rising-edge detect on the reversal input; runs even while EN is low, so a level that rises while disabled is never seen as an edge later.
    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            trig_prev <= 1'b0;
        end else begin
            trig_prev <= TRANS_TRIG;
        end
    end

    assign trig_edge = TRANS_TRIG & ~trig_prev;

    // Main controller: increment on accepted edges, decrement after a quiet period, holdoff after every edge.
    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            res_reg     <= init_clamped;
            state       <= S_RUN;
            quiet_cnt   <= '0;
            hold_cnt    <= '0;
            RES_CHANGED <= 1'b0;
            INC_COUNT   <= 8'd0;
        end else begin
            RES_CHANGED <= 1'b0;
            if (EN) begin
                case (state)
                    S_RUN: begin
                        if (trig_edge) begin
                            if (res_reg < R_MAX_V) begin
                                res_reg     <= res_reg + N_RESISTANCE'(1);
                                RES_CHANGED <= 1'b1;
                                if (INC_COUNT != 8'hFF) begin
                                    INC_COUNT <= INC_COUNT + 8'd1;
                                end
                            end
                            quiet_cnt <= '0;
                            hold_cnt  <= HOLD_LOAD;
                            state     <= S_HOLDOFF;
                        end else if (quiet_cnt == DECAY_TC) begin
                            quiet_cnt <= '0;
                            if (res_reg > R_MIN_V) begin
                                res_reg     <= res_reg - N_RESISTANCE'(1);
                                RES_CHANGED <= 1'b1;
                            end
                        end else begin
                            quiet_cnt <= quiet_cnt + N_DECAY'(1);
                        end
                    end
                    S_HOLDOFF: begin
                        quiet_cnt <= '0;
                        if (hold_cnt == '0) begin
                            state <= S_RUN;
                        end else begin
                            hold_cnt <= hold_cnt - N_HOLD'(1);
                        end
                    end
                    default: begin
                        state     <= S_RUN;
                        quiet_cnt <= '0;
                        hold_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    // While INIT is held the outputs follow the clamped load value directly.
    always_comb begin
        RESISTANCE = INIT ? init_clamped : res_reg;
        AT_MAX     = (RESISTANCE == R_MAX_V);
        AT_MIN     = (RESISTANCE == R_MIN_V);
    end

endmodule

// File: tb/tb_nn_resistance_ctrl.sv
// tb_nn_resistance_ctrl
// Directed testbench for nn_resistance_ctrl with the default parameters
// (R_MIN=1, R_MAX=100, HOLDOFF=16, DECAY_PERIOD=256).

module tb_nn_resistance_ctrl;

    logic       CLK;
    logic       INIT;
    logic       EN;
    logic       TRANS_TRIG;
    logic [8:0] RESISTANCE_INIT;
    logic [8:0] RESISTANCE;
    logic       RES_CHANGED;
    logic       AT_MAX;
    logic       AT_MIN;
    logic [7:0] INC_COUNT;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int base;

    nn_resistance_ctrl dut (
        .CLK             (CLK),
        .INIT            (INIT),
        .EN              (EN),
        .TRANS_TRIG      (TRANS_TRIG),
        .RESISTANCE_INIT (RESISTANCE_INIT),
        .RESISTANCE      (RESISTANCE),
        .RES_CHANGED     (RES_CHANGED),
        .AT_MAX          (AT_MAX),
        .AT_MIN          (AT_MIN),
        .INC_COUNT       (INC_COUNT)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count RES_CHANGED pulses mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (RES_CHANGED === 1'b1) pulse_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_init(input logic [8:0] v);
        INIT = 1'b1;
        RESISTANCE_INIT = v;
        #1;
    endtask

    task automatic release_init();
        tick(1);
        INIT = 1'b0;
    endtask

    task automatic pulse();
        TRANS_TRIG = 1'b1;
        tick(1);
        TRANS_TRIG = 1'b0;
    endtask

    task automatic test_reset();
        INIT = 1'b1;
        RESISTANCE_INIT = 9'd10;
        tick(1);
        checks++; if (RESISTANCE !== 9'd10) begin errors++; $display("[TB] FAIL reset_r10: got %0d expected 10", RESISTANCE); end
        checks++; if (AT_MIN !== 1'b0) begin errors++; $display("[TB] FAIL reset_atmin10: got %0b expected 0", AT_MIN); end
        checks++; if (RES_CHANGED !== 1'b0) begin errors++; $display("[TB] FAIL reset_changed: got %0b expected 0", RES_CHANGED); end
        checks++; if (INC_COUNT !== 8'd0) begin errors++; $display("[TB] FAIL reset_inc: got %0d expected 0", INC_COUNT); end
        apply_init(9'd200);
        checks++; if (RESISTANCE !== 9'd100) begin errors++; $display("[TB] FAIL reset_clamp_hi: got %0d expected 100", RESISTANCE); end
        checks++; if (AT_MAX !== 1'b1) begin errors++; $display("[TB] FAIL reset_atmax: got %0b expected 1", AT_MAX); end
        apply_init(9'd0);
        checks++; if (RESISTANCE !== 9'd1) begin errors++; $display("[TB] FAIL reset_clamp_lo: got %0d expected 1", RESISTANCE); end
        checks++; if (AT_MIN !== 1'b1) begin errors++; $display("[TB] FAIL reset_atmin: got %0b expected 1", AT_MIN); end
    endtask

    task automatic test_single_increment();
        apply_init(9'd10);
        release_init();
        base = pulse_cnt;
        pulse();
        checks++; if (RESISTANCE !== 9'd11) begin errors++; $display("[TB] FAIL inc_first: got %0d expected 11", RESISTANCE); end
        checks++; if (RES_CHANGED !== 1'b1) begin errors++; $display("[TB] FAIL inc_changed_hi: got %0b expected 1", RES_CHANGED); end
        tick(1);
        checks++; if (RES_CHANGED !== 1'b0) begin errors++; $display("[TB] FAIL inc_changed_lo: got %0b expected 0", RES_CHANGED); end
        tick(3);
        pulse();
        checks++; if (RESISTANCE !== 9'd11) begin errors++; $display("[TB] FAIL inc_holdoff_ignored: got %0d expected 11", RESISTANCE); end
        tick(14);
        pulse();
        checks++; if (RESISTANCE !== 9'd12) begin errors++; $display("[TB] FAIL inc_second: got %0d expected 12", RESISTANCE); end
        checks++; if (INC_COUNT !== 8'd2) begin errors++; $display("[TB] FAIL inc_count2: got %0d expected 2", INC_COUNT); end
        tick(2);
        checks++; if (pulse_cnt - base !== 2) begin errors++; $display("[TB] FAIL inc_pulses: got %0d expected 2", pulse_cnt - base); end
    endtask

    task automatic test_level_trigger();
        apply_init(9'd10);
        release_init();
        base = pulse_cnt;
        TRANS_TRIG = 1'b1;
        tick(50);
        TRANS_TRIG = 1'b0;
        tick(2);
        checks++; if (RESISTANCE !== 9'd11) begin errors++; $display("[TB] FAIL level_r: got %0d expected 11", RESISTANCE); end
        checks++; if (INC_COUNT !== 8'd1) begin errors++; $display("[TB] FAIL level_inc: got %0d expected 1", INC_COUNT); end
        checks++; if (pulse_cnt - base !== 1) begin errors++; $display("[TB] FAIL level_pulses: got %0d expected 1", pulse_cnt - base); end
    endtask

    task automatic test_decay();
        apply_init(9'd3);
        release_init();
        base = pulse_cnt;
        tick(255);
        checks++; if (RESISTANCE !== 9'd3) begin errors++; $display("[TB] FAIL decay_255: got %0d expected 3", RESISTANCE); end
        tick(1);
        checks++; if (RESISTANCE !== 9'd2) begin errors++; $display("[TB] FAIL decay_256: got %0d expected 2", RESISTANCE); end
        tick(255);
        checks++; if (RESISTANCE !== 9'd2) begin errors++; $display("[TB] FAIL decay_511: got %0d expected 2", RESISTANCE); end
        tick(1);
        checks++; if (RESISTANCE !== 9'd1) begin errors++; $display("[TB] FAIL decay_512: got %0d expected 1", RESISTANCE); end
        tick(2000 - 512);
        checks++; if (RESISTANCE !== 9'd1) begin errors++; $display("[TB] FAIL decay_2000: got %0d expected 1", RESISTANCE); end
        checks++; if (AT_MIN !== 1'b1) begin errors++; $display("[TB] FAIL decay_atmin: got %0b expected 1", AT_MIN); end
        checks++; if (pulse_cnt - base !== 2) begin errors++; $display("[TB] FAIL decay_pulses: got %0d expected 2", pulse_cnt - base); end
    endtask

    task automatic test_at_max();
        apply_init(9'd100);
        release_init();
        base = pulse_cnt;
        pulse();
        checks++; if (RESISTANCE !== 9'd100) begin errors++; $display("[TB] FAIL max_r: got %0d expected 100", RESISTANCE); end
        checks++; if (INC_COUNT !== 8'd0) begin errors++; $display("[TB] FAIL max_inc: got %0d expected 0", INC_COUNT); end
        tick(5);
        pulse();
        tick(265);
        checks++; if (RESISTANCE !== 9'd100) begin errors++; $display("[TB] FAIL max_no_early_decay: got %0d expected 100", RESISTANCE); end
        checks++; if (pulse_cnt - base !== 0) begin errors++; $display("[TB] FAIL max_pulses: got %0d expected 0", pulse_cnt - base); end
        tick(1);
        checks++; if (RESISTANCE !== 9'd99) begin errors++; $display("[TB] FAIL max_decay: got %0d expected 99", RESISTANCE); end
    endtask

    task automatic test_enable_hold();
        apply_init(9'd10);
        release_init();
        tick(100);
        EN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pulse();
            tick(49);
        end
        checks++; if (RESISTANCE !== 9'd10) begin errors++; $display("[TB] FAIL en_hold_r: got %0d expected 10", RESISTANCE); end
        checks++; if (INC_COUNT !== 8'd0) begin errors++; $display("[TB] FAIL en_hold_inc: got %0d expected 0", INC_COUNT); end
        EN = 1'b1;
        tick(155);
        checks++; if (RESISTANCE !== 9'd10) begin errors++; $display("[TB] FAIL en_resume_pre: got %0d expected 10", RESISTANCE); end
        tick(1);
        checks++; if (RESISTANCE !== 9'd9) begin errors++; $display("[TB] FAIL en_resume_decay: got %0d expected 9", RESISTANCE); end
        tick(255);
        pulse();
        checks++; if (RESISTANCE !== 9'd10) begin errors++; $display("[TB] FAIL tc_edge_wins: got %0d expected 10", RESISTANCE); end
        checks++; if (INC_COUNT !== 8'd1) begin errors++; $display("[TB] FAIL tc_edge_inc: got %0d expected 1", INC_COUNT); end
    endtask

    task automatic test_init_mid_holdoff();
        apply_init(9'd10);
        release_init();
        pulse();
        tick(3);
        apply_init(9'd7);
        checks++; if (RESISTANCE !== 9'd7) begin errors++; $display("[TB] FAIL midinit_r: got %0d expected 7", RESISTANCE); end
        release_init();
        TRANS_TRIG = 1'b1;
        tick(1);
        TRANS_TRIG = 1'b0;
        checks++; if (RESISTANCE !== 9'd8) begin errors++; $display("[TB] FAIL midinit_edge: got %0d expected 8", RESISTANCE); end
        checks++; if (INC_COUNT !== 8'd1) begin errors++; $display("[TB] FAIL midinit_inc: got %0d expected 1", INC_COUNT); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        INIT = 1'b1;
        EN = 1'b1;
        TRANS_TRIG = 1'b0;
        RESISTANCE_INIT = 9'd10;
        test_reset();
        test_single_increment();
        test_level_trigger();
        test_decay();
        test_at_max();
        test_enable_hold();
        test_init_mid_holdoff();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
